// File: rtl/sw_event_if.sv
// Button/event bundle between the raw push buttons and the clock controller.
// All signals are NUM_SW wide, one bit per button.
interface sw_event_if #(
    parameter int NUM_SW = 4
);
    logic [NUM_SW-1:0] i_sw;
    logic [NUM_SW-1:0] o_press;
    logic [NUM_SW-1:0] o_long;
    logic [NUM_SW-1:0] o_rpt;
    logic [NUM_SW-1:0] o_release;
    logic [NUM_SW-1:0] o_held;

    modport master (
        output i_sw,
        input  o_press, o_long, o_rpt, o_release, o_held
    );

    modport slave (
        input  i_sw,
        output o_press, o_long, o_rpt, o_release, o_held
    );
endinterface

// File: rtl/sw_event.sv
// Key-event generator: synchronises and debounces active-low buttons on a shared
// sample tick, then emits press / long / repeat / release strobes per button.
module sw_event_lane #(
    parameter int DB_TICKS     = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic s_i,
    output logic press_o,
    output logic long_o,
    output logic rpt_o,
    output logic release_o,
    output logic held_o
);
    localparam int DW = $clog2(DB_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE, DB_PRESS, PRESSED, REPEAT, DB_RELEASE
    } state_t;

    state_t        state_q, ret_q;
    logic [DW-1:0] dbc_q;
    logic [HW-1:0] hold_q;
    logic [RW-1:0] rpt_q;
    logic          press_q, long_q, rpt_pulse_q, release_q, held_q;

    assign press_o   = press_q;
    assign long_o    = long_q;
    assign rpt_o     = rpt_pulse_q;
    assign release_o = release_q;
    assign held_o    = held_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            dbc_q       <= '0;
            hold_q      <= '0;
            rpt_q       <= '0;
            press_q     <= 1'b0;
            long_q      <= 1'b0;
            rpt_pulse_q <= 1'b0;
            release_q   <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            press_q     <= 1'b0;
            long_q      <= 1'b0;
            rpt_pulse_q <= 1'b0;
            release_q   <= 1'b0;
            if (tick_i) begin
                case (state_q)
                    IDLE: begin
                        if (s_i) begin
                            // A single-sample debounce accepts the press immediately
                            if (DB_TICKS == 1) begin
                                state_q <= PRESSED;
                                press_q <= 1'b1;
                                held_q  <= 1'b1;
                                hold_q  <= '0;
                            end else begin
                                state_q <= DB_PRESS;
                                dbc_q   <= DW'(1);
                            end
                        end
                    end
                    DB_PRESS: begin
                        if (!s_i) begin
                            state_q <= IDLE;
                        end else if (dbc_q == DW'(DB_TICKS - 1)) begin
                            state_q <= PRESSED;
                            dbc_q   <= DW'(DB_TICKS);
                            press_q <= 1'b1;
                            held_q  <= 1'b1;
                            hold_q  <= '0;
                        end else begin
                            dbc_q <= dbc_q + DW'(1);
                        end
                    end
                    PRESSED, REPEAT: begin
                        if (!s_i) begin
                            if (DB_TICKS == 1) begin
                                state_q   <= IDLE;
                                release_q <= 1'b1;
                                held_q    <= 1'b0;
                            end else begin
                                state_q <= DB_RELEASE;
                                ret_q   <= state_q;
                                dbc_q   <= DW'(1);
                            end
                        end else if (state_q == PRESSED) begin
                            hold_q <= hold_q + HW'(1);
                            if (hold_q == HW'(LONG_TICKS - 1)) begin
                                state_q <= REPEAT;
                                long_q  <= 1'b1;
                                rpt_q   <= '0;
                            end
                        end else if (rpt_q == RW'(REPEAT_TICKS - 1)) begin
                            rpt_q       <= '0;
                            rpt_pulse_q <= 1'b1;
                        end else begin
                            rpt_q <= rpt_q + RW'(1);
                        end
                    end
                    DB_RELEASE: begin
                        // A bounce back to pressed resumes where it left off; hold/rpt kept
                        if (s_i) begin
                            state_q <= ret_q;
                        end else if (dbc_q == DW'(DB_TICKS - 1)) begin
                            state_q   <= IDLE;
                            dbc_q     <= DW'(DB_TICKS);
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else begin
                            dbc_q <= dbc_q + DW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

module sw_event #(
    parameter int NUM_SW       = 4,
    parameter int TICK_DIV     = 500000,
    parameter int DB_TICKS     = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    sw_event_if.slave  sw
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              tick;
    logic [NUM_SW-1:0] sync1_q, sync2_q;
    logic [NUM_SW-1:0] press, lng, rpt, rel, held;

    assign tick   = (tcnt_q == TW'(TICK_DIV - 1));
    assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

    // Synchroniser idles at 1 so a reset looks like every button released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q  <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            tcnt_q  <= tcnt_d;
            sync1_q <= sw.i_sw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_SW; g++) begin : g_lane
        sw_event_lane #(
            .DB_TICKS     (DB_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .s_i       (~sync2_q[g]),
            .press_o   (press[g]),
            .long_o    (lng[g]),
            .rpt_o     (rpt[g]),
            .release_o (rel[g]),
            .held_o    (held[g])
        );
    end

    assign sw.o_press   = press;
    assign sw.o_long    = lng;
    assign sw.o_rpt     = rpt;
    assign sw.o_release = rel;
    assign sw.o_held    = held;
endmodule

// File: tb/tb_sw_event.sv
// Bench for sw_event: directed button scenarios plus random chatter, checked
// tick by tick against a counting model of debounced button behaviour.
module tb_sw_event;
    localparam int N   = 4;
    localparam int DB  = 3;
    localparam int LG  = 10;
    localparam int RP  = 4;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ntests = 0;
    int   nfail  = 0;

    sw_event_if #(.NUM_SW(N)) ifc ();

    sw_event #(
        .NUM_SW(N), .TICK_DIV(DIV), .DB_TICKS(DB),
        .LONG_TICKS(LG), .REPEAT_TICKS(RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (ifc.slave)
    );

    always #5 clk = ~clk;

    // Model: debounced level plus run-length counters, one set per button
    int       m_db[N], m_run[N], m_hold[N], m_rpt[N];
    bit       m_long[N];
    logic [N-1:0] e_press, e_long, e_rpt, e_rel, e_held;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_db[i] = 0; m_run[i] = 0; m_hold[i] = 0; m_rpt[i] = 0; m_long[i] = 0;
        end
        e_press = '0; e_long = '0; e_rpt = '0; e_rel = '0; e_held = '0;
    endtask

    task automatic model_tick(input logic [N-1:0] pressed);
        e_press = '0; e_long = '0; e_rpt = '0; e_rel = '0;
        for (int i = 0; i < N; i++) begin
            if (m_db[i] == 0) begin
                if (pressed[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i] = 1; m_run[i] = 0; m_hold[i] = 0; m_long[i] = 0;
                        e_press[i] = 1'b1;
                    end
                end else m_run[i] = 0;
            end else if (!pressed[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i] = 0; m_run[i] = 0; e_rel[i] = 1'b1;
                end
            end else if (m_run[i] > 0) begin
                m_run[i] = 0;
            end else if (!m_long[i]) begin
                m_hold[i]++;
                if (m_hold[i] == LG) begin
                    m_long[i] = 1; m_rpt[i] = 0; e_long[i] = 1'b1;
                end
            end else begin
                m_rpt[i]++;
                if (m_rpt[i] == RP) begin
                    m_rpt[i] = 0; e_rpt[i] = 1'b1;
                end
            end
            e_held[i] = (m_db[i] != 0);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".press"},   32'(ifc.o_press),   32'(e_press));
        chk({tag, ".long"},    32'(ifc.o_long),    32'(e_long));
        chk({tag, ".rpt"},     32'(ifc.o_rpt),     32'(e_rpt));
        chk({tag, ".release"}, 32'(ifc.o_release), 32'(e_rel));
        chk({tag, ".held"},    32'(ifc.o_held),    32'(e_held));
    endtask

    // One sample period: inputs change right after a tick, the next tick sees them
    task automatic step(input string tag, input logic [N-1:0] sw_val);
        ifc.i_sw = sw_val;
        for (int k = 0; k < DIV; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < DIV - 1) begin
                chk({tag, ".quiet_pulses"},
                    32'(ifc.o_press | ifc.o_long | ifc.o_rpt | ifc.o_release), 32'd0);
                chk({tag, ".quiet_held"}, 32'(ifc.o_held), 32'(e_held));
            end else begin
                model_tick(~sw_val);
                chk_all(tag);
            end
        end
    endtask

    task automatic steps(input string tag, input logic [N-1:0] sw_val, input int n);
        for (int i = 0; i < n; i++) step(tag, sw_val);
    endtask

    initial begin
        logic [N-1:0] r;
        model_reset();
        ifc.i_sw = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset");
        rst = 1'b0;

        steps("t1_press0",   4'b1110, 8);
        steps("t1_rel0",     4'b1111, 4);
        steps("t2_bounce1",  4'b1101, 2);
        steps("t2_idle",     4'b1111, 2);
        steps("t3_hold2",    4'b1011, 30);
        steps("t3_rel2",     4'b1111, 4);
        steps("t4_press3",   4'b0111, 5);
        steps("t4_gap3",     4'b1111, 2);
        steps("t4_resume3",  4'b0111, 12);
        steps("t4_rel3",     4'b1111, 4);
        steps("t5_both",     4'b0110, 4);
        steps("t5_rel",      4'b1111, 4);
        steps("t6_rpt2",     4'b1011, 16);

        rst = 1'b1;
        #1;
        model_reset();
        chk_all("t6_reset_now");
        @(negedge clk);
        rst = 1'b0;
        steps("t6_after",    4'b1011, 4);
        steps("t6_rel",      4'b1111, 4);

        r = '1;
        for (int t = 0; t < 250; t++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            step("rand", r);
        end
        steps("final_rel",   4'b1111, 4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
